csr_counter_bank: RTL and testbench

CSR_COUNTER_BANK -- requirements
Module: csr_counter_bank

---
 rtl/csr_counter_bank.sv | 148 ++++++++++++++
 tb/tb_csr_counter_bank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_bank.sv
// Machine-mode performance counter CSR bank: mcycle, minstret, mhpmcounters,
// inhibit/overflow control, with a one-cycle registered CSR access port.
module csr_counter_bank #(
  parameter int NUM_HPM   = 4,
  parameter int COUNTER_W = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req,
  input  logic [11:0]                            addr,
  input  logic [1:0]                             write_mode,
  input  logic [31:0]                            din,
  output logic                                   rsp_valid,
  output logic [31:0]                            dout,
  output logic                                   illegal_address,
  input  logic                                   inst_retired,
  input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event,
  output logic                                   ovf_irq
);

  typedef enum logic [1:0] {
    WM_READ  = 2'b00,
    WM_WRITE = 2'b01,
    WM_SET   = 2'b10,
    WM_CLEAR = 2'b11
  } wmode_e;

  function automatic logic [31:0] impl_mask_f();
    logic [31:0] m;
    m    = '0;
    m[0] = 1'b1;
    m[2] = 1'b1;
    for (int i = 0; i < NUM_HPM; i++) m[3+i] = 1'b1;
    return m;
  endfunction

  // Index 1 (time) is never implemented, so this also hardwires inhibit bit 1.
  localparam logic [31:0] IMPL_MASK = impl_mask_f();

  wmode_e      mode;
  logic [4:0]  idx;
  logic        in_lo, in_hi, sh_lo, sh_hi;
  logic        is_cnt, is_shadow, is_hi, is_inh, is_ovf, is_oen;
  logic        legal, wr_en, cnt_wr;
  logic [31:0] rd_data, wr_val, cnt_en, wrap, ovf_clr;
  logic [31:0] inhibit, ovf, ovf_en;
  logic [63:0] cnt_val [32];

  assign mode = wmode_e'(write_mode);
  assign idx  = addr[4:0];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    in_lo     = (addr[11:5] == 7'h58);
    in_hi     = (addr[11:5] == 7'h5C);
    sh_lo     = (addr[11:5] == 7'h60);
    sh_hi     = (addr[11:5] == 7'h64);
    is_shadow = sh_lo | sh_hi;
    is_hi     = in_hi | sh_hi;
    is_cnt    = (in_lo | in_hi | is_shadow) && (idx != 5'd1);
    is_inh    = (addr == 12'h320);
    is_ovf    = (addr == 12'h7C0);
    is_oen    = (addr == 12'h7C1);
    legal     = (is_cnt && !(is_shadow && mode != WM_READ)) || is_inh || is_ovf || is_oen;
    wr_en     = req && legal && (mode != WM_READ);
    cnt_wr    = wr_en && is_cnt;
  end

  always_comb begin
    rd_data = '0;
    if (legal) begin
      if (is_cnt)      rd_data = is_hi ? cnt_val[idx][63:32] : cnt_val[idx][31:0];
      else if (is_inh) rd_data = inhibit;
      else if (is_ovf) rd_data = ovf;
      else             rd_data = ovf_en;
    end
  end

  // The old half being modified is exactly the pre-write read value.
  always_comb begin
    wr_val = rd_data;
    unique case (mode)
      WM_WRITE: wr_val = din;
      WM_SET:   wr_val = rd_data | din;
      WM_CLEAR: wr_val = rd_data & ~din;
      default:  wr_val = rd_data;
    endcase
  end

  always_comb begin
    cnt_en    = '0;
    cnt_en[0] = 1'b1;
    cnt_en[2] = inst_retired;
    for (int i = 0; i < NUM_HPM; i++) cnt_en[3+i] = hpm_event[i];
  end

  for (genvar k = 0; k < 32; k++) begin : g_cnt
    if (IMPL_MASK[k]) begin : g_impl
      logic [COUNTER_W-1:0] c;
      logic [63:0]          ext;
      logic                 hit, inc;

      assign ext      = 64'(c);
      assign hit      = cnt_wr && (idx == 5'(k));
      assign inc      = cnt_en[k] && !inhibit[k];
      assign wrap[k]  = inc && !hit && (&c);
      assign cnt_val[k] = ext;

      // NOTE: counters are individual flops, not a RAM, so they take the
      // asynchronous reset like any other state.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      c <= '0;
        else if (hit) c <= COUNTER_W'(is_hi ? {wr_val, ext[31:0]} : {ext[63:32], wr_val});
        else if (inc) c <= c + 1'b1;
      end
    end else begin : g_none
      assign wrap[k]    = 1'b0;
      assign cnt_val[k] = '0;
    end
  end

  // Overflow bits only accept write-1-to-clear; a wrap in the same cycle wins.
  assign ovf_clr = (wr_en && is_ovf && mode == WM_CLEAR) ? din : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid       <= 1'b0;
      dout            <= '0;
      illegal_address <= 1'b0;
      inhibit         <= '0;
      ovf             <= '0;
      ovf_en          <= '0;
      ovf_irq         <= 1'b0;
    end else begin
      rsp_valid       <= req;
      dout            <= req ? rd_data : '0;
      illegal_address <= req && !legal;
      if (wr_en && is_inh) inhibit <= wr_val & IMPL_MASK;
      if (wr_en && is_oen) ovf_en  <= wr_val & IMPL_MASK;
      ovf     <= ((ovf & ~ovf_clr) | wrap) & IMPL_MASK;
      ovf_irq <= |(ovf & ovf_en);
    end
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Randomised self-checking bench for csr_counter_bank against a behavioural
// model of the counter bank kept as plain arrays.
module tb_csr_counter_bank;

  localparam int NH = 1;
  localparam int CW = 40;
  localparam logic [63:0] CMASK = (64'd1 << CW) - 64'd1;

  logic        clk, rst, req, inst_retired, rsp_valid, illegal_address, ovf_irq;
  logic [11:0] addr;
  logic [1:0]  write_mode;
  logic [31:0] din, dout;
  logic [0:0]  hpm_event;

  csr_counter_bank #(.NUM_HPM(NH), .COUNTER_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .write_mode(write_mode),
    .din(din), .rsp_valid(rsp_valid), .dout(dout),
    .illegal_address(illegal_address), .inst_retired(inst_retired),
    .hpm_event(hpm_event), .ovf_irq(ovf_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference state: full counter values, control registers, expected outputs.
  logic [63:0] m_cnt [32];
  logic [31:0] m_inh, m_ovf, m_en;
  logic [31:0] exp_dout;
  logic        exp_ill, exp_irq;

  function automatic bit impl(int k);
    return (k == 0) || (k == 2) || (k >= 3 && k < 3 + NH);
  endfunction

  function automatic logic [31:0] impl_bits();
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 32; k++) if (impl(k)) m[k] = 1'b1;
    return m;
  endfunction

  function automatic bit enabled(int k, logic ir, logic hp);
    if (k == 0) return 1'b1;
    if (k == 2) return ir;
    return hp;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_cnt[k] = '0;
    m_inh = '0; m_ovf = '0; m_en = '0;
  endtask

  task automatic model_step(input logic r, input logic [11:0] a, input logic [1:0] m,
                            input logic [31:0] d, input logic ir, input logic hp);
    int ai, n;
    bit lo, hi, sh, is_cnt, legal, wr;
    logic [31:0] old32, new32, wraps, clr;
    ai = int'(a);
    n  = ai % 32;
    lo = (ai >= 'hB00 && ai <= 'hB1F) || (ai >= 'hC00 && ai <= 'hC1F);
    hi = (ai >= 'hB80 && ai <= 'hB9F) || (ai >= 'hC80 && ai <= 'hC9F);
    sh = (ai >= 'hC00);
    is_cnt = (lo || hi) && n != 1;
    legal  = (is_cnt && !(sh && m != 2'd0)) || ai == 'h320 || ai == 'h7C0 || ai == 'h7C1;
    old32 = '0;
    if (legal) begin
      if (is_cnt)           old32 = hi ? m_cnt[n][63:32] : m_cnt[n][31:0];
      else if (ai == 'h320) old32 = m_inh;
      else if (ai == 'h7C0) old32 = m_ovf;
      else                  old32 = m_en;
    end
    case (m)
      2'd1:    new32 = d;
      2'd2:    new32 = old32 | d;
      2'd3:    new32 = old32 & ~d;
      default: new32 = old32;
    endcase
    exp_dout = old32;
    exp_ill  = !legal;
    exp_irq  = |(m_ovf & m_en);
    wr = r && legal && m != 2'd0;
    wraps = '0;
    clr   = '0;
    for (int k = 0; k < 32; k++) begin
      if (!impl(k)) continue;
      if (wr && is_cnt && n == k) begin
        if (hi) m_cnt[k] = ({new32, 32'h0} | (m_cnt[k] & 64'hFFFF_FFFF)) & CMASK;
        else    m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | 64'(new32);
      end else if (enabled(k, ir, hp) && !m_inh[k]) begin
        if (m_cnt[k] == CMASK) begin
          m_cnt[k] = '0;
          wraps[k] = 1'b1;
        end else begin
          m_cnt[k] = m_cnt[k] + 64'd1;
        end
      end
    end
    if (wr && ai == 'h320) m_inh = new32 & impl_bits();
    if (wr && ai == 'h7C1) m_en  = new32 & impl_bits();
    if (wr && ai == 'h7C0 && m == 2'd3) clr = d;
    m_ovf = (m_ovf & ~clr) | wraps;
  endtask

  // One clock cycle: drive, advance the model, then compare just after the edge.
  task automatic step(input logic r, input logic [11:0] a, input logic [1:0] m,
                      input logic [31:0] d, input logic ir, input logic hp);
    req = r; addr = a; write_mode = m; din = d; inst_retired = ir; hpm_event = hp;
    model_step(r, a, m, d, ir, hp);
    @(posedge clk);
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(r));
    if (r) begin
      check($sformatf("dout@%h", a), 64'(dout), 64'(exp_dout));
      check($sformatf("illegal@%h", a), 64'(illegal_address), 64'(exp_ill));
    end
    check("ovf_irq", 64'(ovf_irq), 64'(exp_irq));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 12'h000, 2'd0, 32'h0, 1'b0, 1'b0);
  endtask

  logic [11:0] pool [16] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB80, 12'hB82,
                             12'hB83, 12'hB84, 12'hC00, 12'hC02, 12'hC83, 12'h320,
                             12'h7C0, 12'h7C1, 12'hB01, 12'hB81};

  initial begin
    // A write attempted while reset is asserted must have no effect.
    rst = 1'b1; req = 1'b1; addr = 12'hB00; write_mode = 2'd1; din = 32'h0000_0055;
    inst_retired = 1'b1; hpm_event = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_illegal", 64'(illegal_address), 64'd0);
    check("rst_ovf_irq", 64'(ovf_irq), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ten idle edges after release, then mcycle reads exactly 10.
    idle(10);
    step(1'b1, 12'hB00, 2'd0, 32'h0, 1'b0, 1'b0);
    check("mcycle_after_idle", 64'(dout), 64'd10);
    check("mcycle_legal", 64'(illegal_address), 64'd0);

    // Inhibit minstret while retiring, then release the inhibit.
    step(1'b1, 12'h320, 2'd2, 32'h4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 12'h000, 2'd0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 12'hB02, 2'd0, 32'h0, 1'b0, 1'b0);
    check("minstret_inhibited", 64'(dout), 64'd0);
    step(1'b1, 12'h320, 2'd3, 32'h4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 12'h000, 2'd0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 12'hB02, 2'd0, 32'h0, 1'b0, 1'b0);
    check("minstret_counted", 64'(dout), 64'd5);

    // Only implemented, non-time inhibit bits are writable.
    step(1'b1, 12'h320, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b1, 12'h320, 2'd1, 32'h0, 1'b0, 1'b0);
    check("inhibit_mask", 64'(dout), 64'h0000_000D);

    // Overflow of mhpmcounter3, sticky flag, interrupt, write-1-to-clear.
    step(1'b1, 12'hB83, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b1, 12'hB03, 2'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    step(1'b1, 12'h7C1, 2'd1, 32'h8, 1'b0, 1'b0);
    step(1'b0, 12'h000, 2'd0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 12'h000, 2'd0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 12'hB03, 2'd0, 32'h0, 1'b0, 1'b0);
    check("hpm3_lo_wrapped", 64'(dout), 64'd0);
    step(1'b1, 12'hB83, 2'd0, 32'h0, 1'b0, 1'b0);
    check("hpm3_hi_wrapped", 64'(dout), 64'd0);
    step(1'b1, 12'h7C0, 2'd0, 32'h0, 1'b0, 1'b0);
    check("ovf_bit3", 64'(dout), 64'h8);
    check("ovf_irq_set", 64'(ovf_irq), 64'd1);
    step(1'b1, 12'h7C0, 2'd1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 12'h7C0, 2'd3, 32'h8, 1'b0, 1'b0);
    check("ovf_write_ignored", 64'(dout), 64'h8);
    idle(1);
    check("ovf_irq_cleared", 64'(ovf_irq), 64'd0);

    // Shadow writes fault; shadow reads mirror the counter.
    step(1'b1, 12'hC00, 2'd1, 32'h0, 1'b0, 1'b0);
    check("shadow_write_illegal", 64'(illegal_address), 64'd1);
    step(1'b1, 12'hC00, 2'd0, 32'h0, 1'b0, 1'b0);
    check("shadow_read_legal", 64'(illegal_address), 64'd0);

    // Unimplemented hpm counter, unmapped address, narrow high half.
    step(1'b1, 12'hB04, 2'd0, 32'h0, 1'b0, 1'b0);
    check("hpm4_zero", 64'(dout), 64'd0);
    check("hpm4_legal", 64'(illegal_address), 64'd0);
    step(1'b1, 12'h123, 2'd0, 32'h0, 1'b0, 1'b0);
    check("unmapped_illegal", 64'(illegal_address), 64'd1);
    check("unmapped_dout", 64'(dout), 64'd0);
    step(1'b1, 12'hB80, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step(1'b1, 12'hB80, 2'd0, 32'h0, 1'b0, 1'b0);
    check("mcycleh_upper_zero", 64'(dout[31:8]), 64'd0);
    step(1'b1, 12'hB80, 2'd1, 32'h0, 1'b0, 1'b0);

    // Write and increment in the same cycle: the written value wins.
    step(1'b1, 12'hB02, 2'd1, 32'h0000_1234, 1'b1, 1'b0);
    step(1'b1, 12'hB02, 2'd0, 32'h0, 1'b0, 1'b0);
    check("minstret_write_wins", 64'(dout), 64'h1234);

    // Random traffic, biased toward saturating values so wraps occur.
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 15)];
      d = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom;
      step(1'($urandom), a, 2'($urandom), d, 1'($urandom), 1'($urandom));
    end

    // Reset asserted mid-run clears outputs immediately and drops the access.
    req = 1'b1; addr = 12'hB00; write_mode = 2'd1; din = 32'h0000_DEAD;
    rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_dout", 64'(dout), 64'd0);
    check("async_rst_ovf_irq", 64'(ovf_irq), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    step(1'b1, 12'hB00, 2'd0, 32'h0, 1'b0, 1'b0);
    check("mcycle_after_rerelease", 64'(dout), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
